read_port_arbiter: RTL
======================

Name: read_port_arbiter

Overview:
- Shares one read-memory port among NUM_REQ requesters.
- The memory port is an address-request stream plus a data-response stream. The memory returns responses strictly in request order after a fixed or variable latency.
- The block arbitrates requesters round-robin and tracks up to MAX_OUTSTANDING in-flight reads with an in-order requester-ID FIFO.
- It routes each response back to the requester that issued it. It sits between the DMA/queue engines and the shared read memory.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 48, request address width
DATA_WIDTH, 64, response data width
MAX_OUTSTANDING, 4, ID FIFO depth = max reads granted but not yet answered (power of 2, >=2)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; slice i = requester i
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
mem_req_addr  out  ADDR_WIDTH  address to memory
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory request accept
mem_rsp_data  in  DATA_WIDTH  memory response data
mem_rsp_valid  in  1  memory response valid
mem_rsp_ready  out  1  memory response accept
rsp_data  out  DATA_WIDTH  response data, broadcast to all requesters
rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready  in  NUM_REQ  per-requester response accept
outstanding  out  $clog2(MAX_OUTSTANDING)+1  current ID FIFO occupancy
err_unexpected  out  1  sticky: response arrived with no outstanding read

Behaviour:
Reset (rstn low, asynchronous, any time, including mid-transfer):
- All outputs 0: req_ready, mem_req_valid, mem_req_addr, rsp_valid, mem_rsp_ready, outstanding, err_unexpected.
- Round-robin pointer = 0; ID FIFO emptied.
- In-flight reads are forgotten. Memory responses arriving after reset deassertion count as unexpected.

Handshakes:
- A transfer occurs when valid and ready are both high on a rising edge.
- Once valid is asserted it is held until accepted; the accompanying data/addr stay stable while valid is high.

Request register (states EMPTY / FULL):
- A single output register holds mem_req_addr/mem_req_valid.
- It can load in a cycle when it is EMPTY, or FULL with mem_req_ready=1 (back-to-back issue allowed).
- Load also requires the FIFO not full after this cycle's pop: occupancy - pop < MAX_OUTSTANDING.

Arbitration (combinational grant, registered effects):
- Candidates are requesters with req_valid=1. Search starts at index rr_ptr and wraps modulo NUM_REQ; the first found is granted.
- req_ready[g]=1 only when the register can load; all other req_ready bits are 0.
- On the grant edge:
  - the address slice is copied into the register, which becomes FULL (mem_req_valid=1 on the next cycle; latency 1);
  - g is pushed into the ID FIFO;
  - rr_ptr <= (g+1) mod NUM_REQ.
- With no grant, rr_ptr holds.
- FULL -> EMPTY when mem_req_ready=1 and no new load occurs.

Response routing (zero latency, combinational):
- head = ID FIFO head.
- If the FIFO is non-empty:
  - rsp_valid[head] = mem_rsp_valid; other bits 0;
  - rsp_data = mem_rsp_data;
  - mem_rsp_ready = rsp_ready[head].
- A response handshake pops the FIFO.
- A requester that stalls its rsp_ready stalls all later responses (in-order); no reordering.

Occupancy:
- outstanding = pushes - pops, registered.
- Simultaneous push and pop leaves it unchanged, including when full: with FIFO full and a pop this cycle, a grant is allowed.
- The value covers reads still in the request register plus reads in flight.

Unexpected response:
- mem_rsp_valid=1 with the FIFO empty drives mem_rsp_ready=1 (drain), rsp_valid=0, and sets err_unexpected.
- err_unexpected clears only on reset.

Test Plan:
1. Single read: requester 2 asserts addr 0x1000 -> req_ready[2] at once; mem_req_valid with addr 0x1000 next cycle; memory returns 0xDEAD after 16 cycles -> rsp_valid=4'b0100, rsp_data=0xDEAD; outstanding 1 -> 0.
2. Fairness: all 4 requesters continuously valid, mem_req_ready=1, responses immediate -> grant order 0,1,2,3,0,1,...; each requester gets exactly 25% of grants over 64 grants.
3. Outstanding limit: memory withholds responses -> exactly 4 requests issued, outstanding=4, req_ready all 0. Then one response arrives -> in that same cycle a grant occurs and outstanding stays 4.
4. Response backpressure: reads from requesters 1 then 3 in flight, rsp_ready[1]=0 for 5 cycles -> mem_rsp_ready=0 and requester 3 receives nothing until requester 1 accepts; data arrives in order 1, 3.
5. Unexpected response: mem_rsp_valid pulse with outstanding=0 -> mem_rsp_ready=1, rsp_valid=0, err_unexpected=1 and stays 1.
6. Async reset mid-operation: rstn dropped between clock edges with 3 reads outstanding -> all outputs 0 immediately, without waiting for a clock edge; after release the first grant goes to requester 0; a late response sets err_unexpected.

Source files
------------

// File: rtl/read_port_arbiter.sv
// rtl/read_port_arbiter.sv - round-robin shared read port with in-order response routing
module read_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [ADDR_WIDTH-1:0]               mem_req_addr,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  input  logic [DATA_WIDTH-1:0]               mem_rsp_data,
  input  logic                                mem_rsp_valid,
  output logic                                mem_rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                err_unexpected
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0]  CNT_FULL = CW'(MAX_OUTSTANDING);
  localparam logic [IDW:0]   NUM_W    = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  typedef enum logic {REQ_EMPTY, REQ_FULL} req_state_t;

  req_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [IDW-1:0]        rr_ptr, rr_next;
  logic [IDW-1:0]        id_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [IDW-1:0]        head;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_found;
  logic                  fifo_empty;
  logic                  can_load;
  logic                  push;
  logic                  pop;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign fifo_empty = (count == '0);
  assign head       = id_mem[rd_ptr];

  // Responses follow the ID FIFO head; with nothing outstanding the port drains.
  always_comb begin
    rsp_valid     = '0;
    mem_rsp_ready = 1'b0;
    if (rstn) begin
      if (fifo_empty) begin
        mem_rsp_ready = 1'b1;
      end else begin
        rsp_valid[head] = mem_rsp_valid;
        mem_rsp_ready   = rsp_ready[head];
      end
    end
  end

  assign rsp_data = mem_rsp_data;
  assign pop      = !fifo_empty && mem_rsp_valid && mem_rsp_ready;

  // A same-cycle pop frees a slot, so a full FIFO can still accept a grant.
  assign can_load = ((state_q == REQ_EMPTY) || mem_req_ready) &&
                    !((count == CNT_FULL) && !pop);

  always_comb begin
    logic [IDW:0] cand_w;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_w = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand_w >= NUM_W) begin
        cand_w = cand_w - NUM_W;
      end
      if (!grant_found && req_valid[cand_w[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_w[IDW-1:0];
      end
    end
  end

  assign push    = rstn && grant_found && can_load;
  assign rr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (push) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (push) begin
      state_d = REQ_FULL;
    end else if ((state_q == REQ_FULL) && mem_req_ready) begin
      state_d = REQ_EMPTY;
    end
  end

  assign mem_req_valid = (state_q == REQ_FULL);
  assign mem_req_addr  = addr_q;
  assign outstanding   = count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= REQ_EMPTY;
      addr_q         <= '0;
      rr_ptr         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_unexpected <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        addr_q <= addr_arr[grant_idx];
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= rr_next;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
      if (mem_rsp_valid && fifo_empty) begin
        err_unexpected <= 1'b1;
      end
    end
  end

  // ID storage carries no reset; entries only matter once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr] <= grant_idx;
    end
  end

endmodule
